float_copro_ctrl: RTL and testbench
===================================

# float_copro_ctrl

Sequencing controller for the combinational float coprocessor datapath (add, sub, mul, div). It accepts one operation at a time from the LM32 custom-instruction side and registers the opcode and operands so the datapath inputs stay stable. It then holds those inputs for a per-opcode multicycle latency, captures the datapath result and signals completion with a one-cycle `done_o` pulse. It sits between the CPU-side request logic and the `float_pack`-based datapath instance.

## Interface
Parameters:
- `LAT_ADD`, 2: cycles allowed for opcodes 0 (add) and 1 (sub). Range 1..16.
- `LAT_MUL`, 2: cycles allowed for opcode 2 (mul). Range 1..16.
- `LAT_DIV`, 4: cycles allowed for opcode 3 (div). Range 1..16.

Ports:
- `clk_i` in 1: single clock. All state changes on its rising edge.
- `rst_ni` in 1: asynchronous, active-low reset.
- `start_i` in 1: request strobe. Sampled only in IDLE.
- `opcode_i` in 11: operation code. 0 = add, 1 = sub, 2 = mul, 3 = div; any other value is illegal.
- `op0_i` in 32: first operand.
- `op1_i` in 32: second operand.
- `busy_o` out 1: high in EXEC and DONE.
- `done_o` out 1: one-cycle completion pulse.
- `result_o` out 32: registered result. Held until the next completion.
- `err_o` out 1: illegal-opcode flag. Valid with `done_o` and held until the next accepted start.
- `dp_opcode_o` out 11: registered opcode driven to the datapath.
- `dp_op0_o` out 32: registered first operand driven to the datapath.
- `dp_op1_o` out 32: registered second operand driven to the datapath.
- `dp_result_i` in 32: datapath combinational result.

## Operation
- Three-state FSM: IDLE, EXEC, DONE.
- **IDLE**, on `start_i`=1:
  - Register `opcode_i`, `op0_i` and `op1_i` into `dp_*_o`.
  - Clear `err_o`.
  - Legal opcode: load the 4-bit counter with LAT(opcode)-1 and go to EXEC.
  - Illegal opcode: set `result_o`=0 and `err_o`=1, then go directly to DONE.
- **EXEC**:
  - `dp_*_o` are frozen, which makes the datapath a multicycle path.
  - Counter = 0: capture `dp_result_i` into `result_o` and go to DONE.
  - Otherwise: decrement the counter.
- **DONE**: `done_o`=1 for this single cycle, then return to IDLE unconditionally.
- `start_i` is ignored in EXEC and DONE; it is never queued. A start asserted in the DONE cycle is lost, so the requester must re-assert it in IDLE.
- `dp_*_o` keep their last values in IDLE. They change only when a start is accepted.
- `result_o` and `err_o` never change outside a completion or an accepted start.

## Timing
- Reset (asynchronous assert, synchronous release):
  - FSM goes to IDLE and the counter to 0.
  - `busy_o`, `done_o`, `err_o` are 0.
  - `result_o` and all `dp_*_o` are 0.
- Reset in EXEC or DONE aborts the operation immediately. No `done_o` is produced for the aborted operation.
- Legal latency: with the start accepted at edge E0, EXEC occupies LAT cycles and `result_o` is updated at edge E0+LAT.
  - `done_o` is high in the cycle following edge E0+LAT, i.e. LAT+1 cycles after the start cycle.
  - `busy_o` rises one cycle after the start cycle and falls together with `done_o`.
- Illegal latency: `done_o` and `err_o` are high in the cycle right after the start cycle, and `result_o` is 0.
- Back-to-back throughput: the next start can be accepted in the cycle after DONE. One operation therefore occupies LAT+2 cycles, start cycle included.
- LAT=1: EXEC lasts exactly one cycle, and the counter is loaded with 0.

## Test plan
- Reset defaults: assert `rst_ni`=0 mid-cycle -> all outputs 0 immediately, without waiting for a clock edge. After release, IDLE with `busy_o`=0.
- Add with default parameters: start with opcode 0, op0=0x3F800000, op1=0x40000000 -> `busy_o` high for 3 cycles, `done_o` in the 3rd cycle after start, `result_o`=0x40400000, `err_o`=0.
- Division with `LAT_DIV`=4: op0=0x40C00000, op1=0x40000000 -> `done_o` exactly 5 cycles after start, `result_o`=0x40400000. `dp_op0_o` and `dp_op1_o` stay constant across EXEC even while `op0_i` and `op1_i` toggle.
- Illegal opcode 7: start -> next cycle `done_o`=1, `err_o`=1, `result_o`=0. On the next legal start, `err_o` clears in the cycle after that start.
- Ignored start: hold `start_i`=1 continuously for two mul operations -> starts during EXEC and DONE are ignored. Exactly one `done_o` per 4 cycles, each done followed by an IDLE cycle in which the next start is accepted.
- Abort: pull `rst_ni` low in the 2nd EXEC cycle of a div -> no `done_o`, `result_o`=0. A fresh sub after release completes normally.

Source files
------------

// File: rtl/float_copro_ctrl.sv
// Sequencing controller for the multicycle float coprocessor datapath.
// Latches one request, holds the datapath inputs for the opcode's latency, then captures the result.
module float_copro_ctrl #(
    parameter int unsigned LAT_ADD = 2,
    parameter int unsigned LAT_MUL = 2,
    parameter int unsigned LAT_DIV = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [10:0] opcode_i,
    input  logic [31:0] op0_i,
    input  logic [31:0] op1_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] result_o,
    output logic        err_o,
    output logic [10:0] dp_opcode_o,
    output logic [31:0] dp_op0_o,
    output logic [31:0] dp_op1_o,
    input  logic [31:0] dp_result_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [31:0] result_q, result_d;
    logic [10:0] dp_opcode_q, dp_opcode_d;
    logic [31:0] dp_op0_q, dp_op0_d;
    logic [31:0] dp_op1_q, dp_op1_d;

    function automatic logic opc_legal(input logic [10:0] opc);
        return (opc < 11'd4);
    endfunction

    // Counter preload is latency minus one, so LAT=1 means a single EXEC cycle.
    function automatic logic [3:0] lat_m1(input logic [10:0] opc);
        logic [3:0] l;
        case (opc)
            11'd0, 11'd1: l = 4'(LAT_ADD - 32'd1);
            11'd2:        l = 4'(LAT_MUL - 32'd1);
            11'd3:        l = 4'(LAT_DIV - 32'd1);
            default:      l = 4'd0;
        endcase
        return l;
    endfunction

    // Next-state and registered-output computation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        result_d    = result_q;
        dp_opcode_d = dp_opcode_q;
        dp_op0_d    = dp_op0_q;
        dp_op1_d    = dp_op1_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    dp_opcode_d = opcode_i;
                    dp_op0_d    = op0_i;
                    dp_op1_d    = op1_i;
                    err_d       = 1'b0;
                    if (opc_legal(opcode_i)) begin
                        cnt_d   = lat_m1(opcode_i);
                        state_d = ST_EXEC;
                    end else begin
                        result_d = 32'd0;
                        err_d    = 1'b1;
                        state_d  = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (cnt_q == 4'd0) begin
                    result_d = dp_result_i;
                    state_d  = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            result_q    <= 32'd0;
            dp_opcode_q <= 11'd0;
            dp_op0_q    <= 32'd0;
            dp_op1_q    <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            result_q    <= result_d;
            dp_opcode_q <= dp_opcode_d;
            dp_op0_q    <= dp_op0_d;
            dp_op1_q    <= dp_op1_d;
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign result_o    = result_q;
    assign dp_opcode_o = dp_opcode_q;
    assign dp_op0_o    = dp_op0_q;
    assign dp_op1_o    = dp_op1_q;

endmodule

// File: tb/tb_float_copro_ctrl.sv
// Self-checking bench for float_copro_ctrl: vector table, scoreboard of expected completions,
// and directed sequences for held start, illegal opcodes and reset abort.
module tb_float_copro_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic [10:0] opcode_i;
    logic [31:0] op0_i;
    logic [31:0] op1_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;
    logic        err_o;
    logic [10:0] dp_opcode_o;
    logic [31:0] dp_op0_o;
    logic [31:0] dp_op1_o;
    logic [31:0] dp_result_i;

    float_copro_ctrl #(.LAT_ADD(2), .LAT_MUL(2), .LAT_DIV(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .opcode_i(opcode_i),
        .op0_i(op0_i), .op1_i(op1_i), .busy_o(busy_o), .done_o(done_o),
        .result_o(result_o), .err_o(err_o), .dp_opcode_o(dp_opcode_o),
        .dp_op0_o(dp_op0_o), .dp_op1_o(dp_op1_o), .dp_result_i(dp_result_i)
    );

    always #5 clk_i = ~clk_i;

    // Datapath stub: exact floats for the known test pairs, a scrambled mix otherwise.
    function automatic logic [31:0] fake_dp(input logic [10:0] opc, input logic [31:0] a,
                                            input logic [31:0] b);
        if (opc == 11'd0 && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        if (opc == 11'd3 && a == 32'h40C00000 && b == 32'h40000000) return 32'h40400000;
        return a + {b[15:0], b[31:16]} + {21'd0, opc};
    endfunction

    always_comb dp_result_i = fake_dp(dp_opcode_o, dp_op0_o, dp_op1_o);

    typedef struct {
        int          done_cyc;
        logic [31:0] res;
        logic        err;
    } sb_t;

    typedef struct {
        logic [10:0] opc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        err;
        int          lat;
    } vec_t;

    sb_t  sb_q[$];
    vec_t vecs[8];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   done_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
        chk({tag, "_done"}, {31'd0, done_o}, 32'd0);
        chk({tag, "_err"}, {31'd0, err_o}, 32'd0);
        chk({tag, "_result"}, result_o, 32'd0);
        chk({tag, "_dp_opcode"}, {21'd0, dp_opcode_o}, 32'd0);
        chk({tag, "_dp_op0"}, dp_op0_o, 32'd0);
        chk({tag, "_dp_op1"}, dp_op1_o, 32'd0);
    endtask

    // One clock, sampled 1 time unit after the edge; completions are matched against the scoreboard.
    task automatic tick();
        sb_t e;
        @(posedge clk_i);
        #1;
        cyc++;
        if (done_o === 1'b1) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("done_cycle", 32'(cyc), 32'(e.done_cyc));
                chk("done_result", result_o, e.res);
                chk("done_err", {31'd0, err_o}, {31'd0, e.err});
            end
        end
    endtask

    task automatic run_op(input logic [10:0] opc, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] res, input logic err, input int lat);
        sb_t e;
        int  d0;
        int  busy_n;
        start_i  = 1'b1;
        opcode_i = opc;
        op0_i    = a;
        op1_i    = b;
        e.done_cyc = cyc + 1 + lat;
        e.res      = res;
        e.err      = err;
        sb_q.push_back(e);
        d0 = done_cnt;
        tick();
        start_i = 1'b0;
        chk("busy_after_start", {31'd0, busy_o}, 32'd1);
        chk("err_after_start", {31'd0, err_o}, {31'd0, err});
        busy_n = 1;
        for (int i = 0; i < 40 && done_cnt == d0; i++) begin
            op0_i = $urandom;
            op1_i = $urandom;
            chk("dp_op0_frozen", dp_op0_o, a);
            chk("dp_op1_frozen", dp_op1_o, b);
            tick();
            if (busy_o) busy_n++;
        end
        if (done_cnt == d0) chk("done_timeout", 32'd0, 32'd1);
        chk("busy_cycles", 32'(busy_n), 32'(lat + 1));
        tick();
        chk("idle_busy", {31'd0, busy_o}, 32'd0);
        chk("idle_done", {31'd0, done_o}, 32'd0);
        chk("idle_result_held", result_o, res);
        chk("idle_err_held", {31'd0, err_o}, {31'd0, err});
        chk("idle_dp_opcode_held", {21'd0, dp_opcode_o}, {21'd0, opc});
    endtask

    initial begin
        sb_t e;
        int  k;
        int  d0;
        rst_ni   = 1'b0;
        start_i  = 1'b0;
        opcode_i = 11'd0;
        op0_i    = 32'd0;
        op1_i    = 32'd0;

        vecs[0] = '{11'd0, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b0, 2};
        vecs[1] = '{11'd1, 32'h12345678, 32'h9ABCDEF0, 32'h0, 1'b0, 2};
        vecs[2] = '{11'd2, 32'hDEADBEEF, 32'h00C0FFEE, 32'h0, 1'b0, 2};
        vecs[3] = '{11'd3, 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 4};
        vecs[4] = '{11'd7, 32'hAAAA5555, 32'h5555AAAA, 32'h0, 1'b1, 0};
        vecs[5] = '{11'd0, 32'h01020304, 32'h0A0B0C0D, 32'h0, 1'b0, 2};
        vecs[6] = '{11'h7FF, 32'hFFFFFFFF, 32'h00000001, 32'h0, 1'b1, 0};
        vecs[7] = '{11'd4, 32'h11111111, 32'h22222222, 32'h0, 1'b1, 0};
        for (int i = 0; i < 8; i++) begin
            if (!vecs[i].err && vecs[i].res == 32'h0)
                vecs[i].res = fake_dp(vecs[i].opc, vecs[i].a, vecs[i].b);
        end

        repeat (2) tick();
        rst_ni = 1'b1;
        tick();
        chk_all_zero("reset");

        for (int i = 0; i < 8; i++)
            run_op(vecs[i].opc, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].err, vecs[i].lat);

        // Leave nonzero state behind, then reset mid-cycle and check without a clock edge.
        run_op(vecs[3].opc, vecs[3].a, vecs[3].b, vecs[3].res, vecs[3].err, vecs[3].lat);
        #2;
        rst_ni = 1'b0;
        #1;
        chk_all_zero("async_reset");
        tick();
        rst_ni = 1'b1;
        tick();
        chk_all_zero("post_release");

        // Start held high across two mul operations: accepts at k+1 and k+5 only.
        k = cyc;
        start_i  = 1'b1;
        opcode_i = 11'd2;
        op0_i    = 32'h0BADF00D;
        op1_i    = 32'h00FACADE;
        e.res      = fake_dp(11'd2, 32'h0BADF00D, 32'h00FACADE);
        e.err      = 1'b0;
        e.done_cyc = k + 3;
        sb_q.push_back(e);
        e.done_cyc = k + 7;
        sb_q.push_back(e);
        d0 = done_cnt;
        repeat (5) tick();
        start_i = 1'b0;
        repeat (8) tick();
        chk("held_start_done_count", 32'(done_cnt - d0), 32'd2);
        chk("held_start_sb_empty", 32'(sb_q.size()), 32'd0);

        // Abort a div in its second EXEC cycle.
        start_i  = 1'b1;
        opcode_i = 11'd3;
        op0_i    = 32'h40C00000;
        op1_i    = 32'h40000000;
        e.done_cyc = cyc + 5;
        e.res      = 32'h40400000;
        e.err      = 1'b0;
        sb_q.push_back(e);
        tick();
        start_i = 1'b0;
        tick();
        rst_ni = 1'b0;
        #1;
        sb_q.delete();
        chk_all_zero("abort");
        d0 = done_cnt;
        repeat (2) tick();
        rst_ni = 1'b1;
        repeat (8) tick();
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
        chk("abort_result", result_o, 32'd0);
        chk("abort_busy", {31'd0, busy_o}, 32'd0);
        run_op(11'd1, 32'h3F800000, 32'h3F000000, fake_dp(11'd1, 32'h3F800000, 32'h3F000000),
               1'b0, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
